axi_rd_arbiter: RTL and testbench

//  Shares the single AXI read master port (AR + R channels) between NREQ read clients.

---
 rtl/mnet_axi_pkg.sv | 12 +
 rtl/axi_rd_arbiter_rr_pick.sv | 29 ++
 rtl/axi_rd_arbiter.sv | 126 ++++++++++++
 tb/tb_axi_rd_arbiter.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mnet_axi_pkg.sv
// Shared types for the AXI read-port arbiter: FSM state encoding and burst-code width.
package mnet_axi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA
  } arb_state_e;

  localparam int BURST_CODE_W = 4;

endpackage

// File: rtl/axi_rd_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker; the first requester at or after ptr wins.
module rr_pick #(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]         gnt,
  output logic [$clog2(NREQ)-1:0] idx
);

  localparam int IW = $clog2(NREQ);

  logic found;

  // Scan from ptr with wrap-around; the modulo keeps non-power-of-two NREQ in range.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    for (int off = 0; off < NREQ; off++) begin
      if (!found && req[(int'(ptr) + off) % NREQ]) begin
        found = 1'b1;
        gnt[(int'(ptr) + off) % NREQ] = 1'b1;
        idx = IW'((int'(ptr) + off) % NREQ);
      end
    end
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: round-robin sharing of one AXI read port (AR+R) among NREQ clients.
// Optional macro RLAST_CHECK_EN adds a beat counter that flags bursts whose rlast is misplaced.
module axi_rd_arbiter
  import mnet_axi_pkg::*;
#(
  parameter int DW    = 32,
  parameter int AW    = 32,
  parameter int NREQ  = 2,
  parameter int BURST = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NREQ-1:0]              req_arvalid,
  input  logic [NREQ*AW-1:0]           req_araddr,
  input  logic [NREQ*BURST_CODE_W-1:0] req_arburst,
  output logic [NREQ-1:0]              req_arready,
  output logic [NREQ-1:0]              req_rvalid,
  output logic [DW-1:0]                req_rdata,
  output logic [NREQ-1:0]              req_rlast,
  output logic                         arvalid,
  output logic [AW-1:0]                araddr,
  output logic [BURST_CODE_W-1:0]      arburst,
  input  logic                         arready,
  input  logic                         rvalid,
  input  logic [DW-1:0]                rdata,
  input  logic                         rlast,
  output logic                         busy,
  output logic [$clog2(NREQ)-1:0]      gnt_id,
  output logic                         err_len
);

  localparam int IW = $clog2(NREQ);

  if (NREQ < 2 || NREQ > 8 || BURST < 1) begin : g_bad_param
    $error("axi_rd_arbiter: NREQ must be 2..8 and BURST at least 1");
  end

  arb_state_e      state;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   rr_next;
  logic [IW-1:0]   pick_idx;
  logic [NREQ-1:0] pick_onehot;
  logic [NREQ-1:0] gnt_onehot;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req (req_arvalid),
    .ptr (rr_ptr),
    .gnt (pick_onehot),
    .idx (pick_idx)
  );

  assign gnt_onehot = NREQ'(1) << gnt_id;
  assign rr_next    = (gnt_id == IW'(NREQ - 1)) ? '0 : gnt_id + IW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      gnt_id  <= '0;
      arvalid <= 1'b0;
      araddr  <= '0;
      arburst <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|pick_onehot) begin
            gnt_id  <= pick_idx;
            araddr  <= req_araddr[int'(pick_idx)*AW +: AW];
            arburst <= req_arburst[int'(pick_idx)*BURST_CODE_W +: BURST_CODE_W];
            arvalid <= 1'b1;
            state   <= ADDR;
          end
        end
        ADDR: begin
          if (arready) begin
            arvalid <= 1'b0;
            state   <= DATA;
          end
        end
        DATA: begin
          // Pointer moves past the finished client so the others get the next turn.
          if (rvalid && rlast) begin
            rr_ptr <= rr_next;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Handshake and beat routing are zero-latency; beats outside DATA go nowhere.
  assign busy        = (state != IDLE);
  assign req_arready = (state == ADDR && arready) ? gnt_onehot : '0;
  assign req_rvalid  = (state == DATA && rvalid) ? gnt_onehot : '0;
  assign req_rlast   = (state == DATA && rvalid && rlast) ? gnt_onehot : '0;
  assign req_rdata   = (state == DATA) ? rdata : '0;

`ifdef RLAST_CHECK_EN
  localparam int CW = $clog2(BURST) + 1;

  logic [CW-1:0] beat_cnt;
  logic [CW-1:0] beat_num;

  assign beat_num = beat_cnt + CW'(1);

  // Counter is zeroed while waiting in ADDR, so every burst starts counting at beat 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt <= '0;
      err_len  <= 1'b0;
    end else begin
      err_len <= 1'b0;
      if (state == ADDR) begin
        beat_cnt <= '0;
      end else if (state == DATA && rvalid) begin
        beat_cnt <= beat_num;
        err_len  <= (rlast != (beat_num == CW'(BURST)));
      end
    end
  end
`else
  assign err_len = 1'b0;
`endif

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Bench for axi_rd_arbiter: vector table, directed corner sequences and a randomized run against a transaction-level model.
module tb_axi_rd_arbiter;

  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int NREQ  = 2;
  localparam int BURST = 16;
  localparam int IW    = $clog2(NREQ);
  localparam int NVEC  = 12;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req_arvalid;
  logic [NREQ*AW-1:0]   req_araddr;
  logic [NREQ*4-1:0]    req_arburst;
  logic [NREQ-1:0]      req_arready;
  logic [NREQ-1:0]      req_rvalid;
  logic [DW-1:0]        req_rdata;
  logic [NREQ-1:0]      req_rlast;
  logic                 arvalid;
  logic [AW-1:0]        araddr;
  logic [3:0]           arburst;
  logic                 arready;
  logic                 rvalid;
  logic [DW-1:0]        rdata;
  logic                 rlast;
  logic                 busy;
  logic [IW-1:0]        gnt_id;
  logic                 err_len;

  logic [AW-1:0] reqAddr  [NREQ];
  logic [3:0]    reqBurst [NREQ];

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic [NREQ-1:0] req;
    logic            ar;
    logic            rv;
    logic            rl;
    logic            expArvalid;
    logic            expBusy;
    logic [IW-1:0]   expGnt;
    logic [NREQ-1:0] expArrdy;
    logic [NREQ-1:0] expRv;
    logic [NREQ-1:0] expRl;
    logic [AW-1:0]   expAddr;
  } vec_t;

  vec_t vecs [NVEC];

  // transaction-level reference state for the randomized run
  int              owner;
  int              lastDone;
  int              lastGrant;
  int              beatsLeft;
  int              beatCnt;
  int              cand;
  int              pulses;
  bit              addrPh;
  bit              expErr;
  bit              cliActive [NREQ];
  logic [AW-1:0]   mAddr;
  logic [3:0]      mBurst;
  logic [NREQ-1:0] rv_v;
  logic            r_ar, r_rv, r_rl;
  logic [DW-1:0]   r_d;
  logic [NREQ-1:0] eArr, eRv, eRl;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      req_araddr[i*AW +: AW] = reqAddr[i];
      req_arburst[i*4 +: 4]  = reqBurst[i];
    end
  end

  axi_rd_arbiter #(.DW(DW), .AW(AW), .NREQ(NREQ), .BURST(BURST)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_arvalid (req_arvalid),
    .req_araddr  (req_araddr),
    .req_arburst (req_arburst),
    .req_arready (req_arready),
    .req_rvalid  (req_rvalid),
    .req_rdata   (req_rdata),
    .req_rlast   (req_rlast),
    .arvalid     (arvalid),
    .araddr      (araddr),
    .arburst     (arburst),
    .arready     (arready),
    .rvalid      (rvalid),
    .rdata       (rdata),
    .rlast       (rlast),
    .busy        (busy),
    .gnt_id      (gnt_id),
    .err_len     (err_len)
  );

  // Drive one cycle of inputs just after the rising edge, return at the falling edge for sampling.
  task automatic applyStimulus(input logic r, input logic [NREQ-1:0] v, input logic ar,
                               input logic rv, input logic rl, input logic [DW-1:0] d);
    @(posedge clk);
    #2;
    rst         = r;
    req_arvalid = v;
    arready     = ar;
    rvalid      = rv;
    rlast       = rl;
    rdata       = d;
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic doReset();
    applyStimulus(1'b1, '0, 1'b0, 1'b0, 1'b0, '0);
    applyStimulus(1'b1, '0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  // Request from idle, then accept the address on the following cycle.
  task automatic startBurst(input int c, input logic [AW-1:0] a);
    reqAddr[c]  = a;
    reqBurst[c] = 4'hF;
    applyStimulus(1'b0, NREQ'(1 << c), 1'b0, 1'b0, 1'b0, '0);
    checkOutput("req_cycle_arvalid", arvalid, 1'b0);
    applyStimulus(1'b0, NREQ'(1 << c), 1'b1, 1'b0, 1'b0, '0);
    checkOutput("ar_arvalid", arvalid, 1'b1);
    checkOutput("ar_araddr", araddr, a);
    checkOutput("ar_arburst", arburst, 4'hF);
    checkOutput("ar_gnt_id", gnt_id, c);
    checkOutput("ar_req_arready", req_arready, NREQ'(1 << c));
  endtask

  task automatic runBurst(input int c, input logic [AW-1:0] a, input int nb);
    startBurst(c, a);
    for (int b = 1; b <= nb; b++) begin
      applyStimulus(1'b0, '0, 1'b0, 1'b1, (b == nb), DW'(32'hB000_0000 + b));
      checkOutput($sformatf("beat%0d_rvalid", b), req_rvalid, NREQ'(1 << c));
      checkOutput($sformatf("beat%0d_rlast", b), req_rlast, (b == nb) ? NREQ'(1 << c) : NREQ'(0));
      checkOutput($sformatf("beat%0d_rdata", b), req_rdata, 32'hB000_0000 + b);
    end
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
    checkOutput("after_burst_busy", busy, 1'b0);
    checkOutput("after_burst_arvalid", arvalid, 1'b0);
    checkOutput("after_burst_err_len", err_len, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; req_arvalid = '0; arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      reqAddr[i] = '0; reqBurst[i] = '0;
    end

    // grant order 0,1,0,1 with one-beat bursts and stray beats in IDLE/ADDR
    vecs[0]  = '{2'b11, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 32'h0};
    vecs[1]  = '{2'b11, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'b01, 2'b00, 2'b00, 32'h100};
    vecs[2]  = '{2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b01, 2'b01, 32'h0};
    vecs[3]  = '{2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 32'h0};
    vecs[4]  = '{2'b11, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'b10, 2'b00, 2'b00, 32'h200};
    vecs[5]  = '{2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 2'b10, 2'b10, 32'h0};
    vecs[6]  = '{2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 32'h0};
    vecs[7]  = '{2'b11, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b01, 2'b00, 2'b00, 32'h100};
    vecs[8]  = '{2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b01, 2'b01, 32'h0};
    vecs[9]  = '{2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 32'h0};
    vecs[10] = '{2'b11, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'b10, 2'b00, 2'b00, 32'h200};
    vecs[11] = '{2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 2'b10, 2'b10, 32'h0};

    $display("[TB] reset state");
    doReset();
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF);
    checkOutput("rst_arvalid", arvalid, 1'b0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_gnt_id", gnt_id, '0);
    checkOutput("rst_araddr", araddr, '0);
    checkOutput("rst_arburst", arburst, '0);
    checkOutput("rst_req_arready", req_arready, '0);
    checkOutput("rst_req_rvalid", req_rvalid, '0);
    checkOutput("rst_req_rlast", req_rlast, '0);
    checkOutput("rst_req_rdata", req_rdata, '0);
    checkOutput("rst_err_len", err_len, 1'b0);

    $display("[TB] vector table");
    doReset();
    reqAddr[0] = 32'h100; reqAddr[1] = 32'h200;
    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(1'b0, vecs[i].req, vecs[i].ar, vecs[i].rv, vecs[i].rl, DW'(32'hA5A5_0000 + i));
      checkOutput($sformatf("vec%0d_arvalid", i), arvalid, vecs[i].expArvalid);
      checkOutput($sformatf("vec%0d_busy", i), busy, vecs[i].expBusy);
      checkOutput($sformatf("vec%0d_gnt_id", i), gnt_id, vecs[i].expGnt);
      checkOutput($sformatf("vec%0d_req_arready", i), req_arready, vecs[i].expArrdy);
      checkOutput($sformatf("vec%0d_req_rvalid", i), req_rvalid, vecs[i].expRv);
      checkOutput($sformatf("vec%0d_req_rlast", i), req_rlast, vecs[i].expRl);
      if (vecs[i].expArvalid)
        checkOutput($sformatf("vec%0d_araddr", i), araddr, vecs[i].expAddr);
    end

    $display("[TB] full 16-beat burst for client 0");
    doReset();
    runBurst(0, 32'h100, 16);

    $display("[TB] arready held low");
    doReset();
    reqAddr[1] = 32'h300; reqBurst[1] = 4'hF;
    pulses = 0;
    applyStimulus(1'b0, 2'b10, 1'b0, 1'b0, 1'b0, '0);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b0, 2'b10, 1'b0, 1'b0, 1'b0, '0);
      checkOutput($sformatf("stall%0d_arvalid", k), arvalid, 1'b1);
      checkOutput($sformatf("stall%0d_araddr", k), araddr, 32'h300);
      if (req_arready != '0) pulses++;
    end
    applyStimulus(1'b0, 2'b10, 1'b1, 1'b0, 1'b0, '0);
    checkOutput("stall_accept_req_arready", req_arready, 2'b10);
    if (req_arready != '0) pulses++;
    applyStimulus(1'b0, 2'b00, 1'b1, 1'b0, 1'b0, '0);
    if (req_arready != '0) pulses++;
    checkOutput("stall_pulse_count", pulses, 1);

    $display("[TB] request during another burst");
    doReset();
    reqAddr[1] = 32'h400; reqBurst[1] = 4'h3;
    startBurst(0, 32'h140);
    for (int b = 1; b <= 16; b++) begin
      applyStimulus(1'b0, (b >= 3) ? 2'b10 : 2'b00, 1'b0, 1'b1, (b == 16), DW'(b));
      checkOutput($sformatf("ovl_beat%0d_rvalid", b), req_rvalid, 2'b01);
    end
    applyStimulus(1'b0, 2'b10, 1'b0, 1'b0, 1'b0, '0);
    checkOutput("ovl_gap_arvalid", arvalid, 1'b0);
    checkOutput("ovl_gap_busy", busy, 1'b0);
    applyStimulus(1'b0, 2'b10, 1'b0, 1'b0, 1'b0, '0);
    checkOutput("ovl_next_arvalid", arvalid, 1'b1);
    checkOutput("ovl_next_gnt_id", gnt_id, 1);
    checkOutput("ovl_next_araddr", araddr, 32'h400);

    $display("[TB] reset mid-burst");
    doReset();
    startBurst(0, 32'h500);
    for (int b = 1; b <= 8; b++)
      applyStimulus((b == 8), 2'b00, 1'b0, 1'b1, 1'b0, DW'(b));
    applyStimulus(1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 32'h9);
    checkOutput("midrst_busy", busy, 1'b0);
    checkOutput("midrst_arvalid", arvalid, 1'b0);
    checkOutput("midrst_araddr", araddr, '0);
    checkOutput("midrst_gnt_id", gnt_id, '0);
    checkOutput("midrst_req_rvalid", req_rvalid, '0);
    checkOutput("midrst_req_rdata", req_rdata, '0);
    checkOutput("midrst_err_len", err_len, 1'b0);
    for (int b = 10; b <= 16; b++) begin
      applyStimulus(1'b0, 2'b00, 1'b0, 1'b1, (b == 16), DW'(b));
      checkOutput($sformatf("midrst_beat%0d_rvalid", b), req_rvalid, '0);
      checkOutput($sformatf("midrst_beat%0d_rlast", b), req_rlast, '0);
    end
    runBurst(0, 32'h180, 16);

    $display("[TB] early rlast");
    doReset();
    startBurst(0, 32'h600);
    pulses = 0;
    for (int b = 1; b <= 10; b++) begin
      applyStimulus(1'b0, 2'b00, 1'b0, 1'b1, (b == 10), DW'(b));
      if (err_len) pulses++;
    end
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, '0);
      if (err_len) pulses++;
    end
    checkOutput("early_rlast_busy", busy, 1'b0);
`ifdef RLAST_CHECK_EN
    checkOutput("early_rlast_err_pulses", pulses, 1);
`else
    checkOutput("early_rlast_err_pulses", pulses, 0);
`endif

    $display("[TB] randomized run");
    doReset();
    owner = -1; lastDone = NREQ - 1; lastGrant = 0; beatsLeft = 0; beatCnt = 0;
    addrPh = 1'b0; expErr = 1'b0; mAddr = '0; mBurst = '0;
    for (int i = 0; i < NREQ; i++) cliActive[i] = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!cliActive[i]) begin
          if ($urandom_range(0, 2) == 0) begin
            cliActive[i] = 1'b1;
            reqAddr[i]   = AW'($urandom);
            reqBurst[i]  = 4'($urandom);
          end
        end else if (owner != i && $urandom_range(0, 19) == 0) begin
          cliActive[i] = 1'b0;
        end
        rv_v[i] = cliActive[i];
      end
      r_ar = 1'($urandom_range(0, 1));
      if (owner >= 0 && !addrPh) begin
        r_rv = ($urandom_range(0, 3) != 0);
        r_rl = r_rv && (beatsLeft == 1);
      end else begin
        r_rv = ($urandom_range(0, 4) == 0);
        r_rl = 1'($urandom_range(0, 1));
      end
      r_d = DW'($urandom);
      applyStimulus(1'b0, rv_v, r_ar, r_rv, r_rl, r_d);

      eArr = '0; eRv = '0; eRl = '0;
      if (owner >= 0 && addrPh && r_ar) eArr[owner] = 1'b1;
      if (owner >= 0 && !addrPh && r_rv) begin
        eRv[owner] = 1'b1;
        eRl[owner] = r_rl;
      end
      checkOutput("rnd_busy", busy, (owner >= 0));
      checkOutput("rnd_arvalid", arvalid, (owner >= 0 && addrPh));
      checkOutput("rnd_gnt_id", gnt_id, lastGrant);
      checkOutput("rnd_req_arready", req_arready, eArr);
      checkOutput("rnd_req_rvalid", req_rvalid, eRv);
      checkOutput("rnd_req_rlast", req_rlast, eRl);
      if (owner >= 0 && addrPh) begin
        checkOutput("rnd_araddr", araddr, mAddr);
        checkOutput("rnd_arburst", arburst, mBurst);
      end
      if (eRv != '0) checkOutput("rnd_req_rdata", req_rdata, r_d);
`ifdef RLAST_CHECK_EN
      checkOutput("rnd_err_len", err_len, expErr);
`else
      checkOutput("rnd_err_len", err_len, 1'b0);
`endif

      expErr = 1'b0;
      if (owner < 0) begin
        for (int k = 0; k < NREQ; k++) begin
          cand = (lastDone + 1 + k) % NREQ;
          if (owner < 0 && rv_v[cand]) begin
            owner = cand; addrPh = 1'b1; lastGrant = cand;
            mAddr = reqAddr[cand]; mBurst = reqBurst[cand];
          end
        end
      end else if (addrPh) begin
        if (r_ar) begin
          addrPh = 1'b0;
          cliActive[owner] = 1'b0;
          beatCnt = 0;
          beatsLeft = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 16)) : BURST;
        end
      end else if (r_rv) begin
        beatCnt++;
        beatsLeft--;
        expErr = (r_rl != (beatCnt == BURST));
        if (r_rl) begin
          lastDone = owner;
          owner = -1;
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
